hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard-detection and forwarding-select unit for the pipelined CPU core. It tracks every in-flight register-writing instruction from issue (ID→EX) to writeback. For each ID-stage source operand it returns a load-use stall and the pipeline distance of the youngest in-flight producer. It adds interlocking and forwarding to the five-stage pipeline generically, for any depth and load latency. It also keeps a saturating stall-cycle counter.

## Interface
Parameters:
- ADDR_W, 5, register address width (x0 = address 0, never a hazard)
- DEPTH, 3, in-flight slots tracked (stages from EX through WB)
- LOAD_DIST, 2, minimum distance at which a load result is forwardable
- DIST_W, 2, width of distance outputs; must hold DEPTH
- CNT_W, 16, stall counter width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- issue_i  in  1  ID-stage instruction requests to advance to EX
- kill_i  in  1  ID instruction is flushed (branch taken); suppresses issue
- rd_i  in  ADDR_W  destination of ID instruction
- rd_wen_i  in  1  ID instruction writes rd
- is_load_i  in  1  ID instruction is a load
- rs1_i, rs2_i  in  ADDR_W  ID source registers
- rs1_used_i, rs2_used_i  in  1  source actually read
- stall_o  out  1  hold PC and IF/ID, insert bubble into EX
- dist1_o, dist2_o  out  DIST_W  0 = read register file; k = forward from producer k stages ahead
- stall_cnt_o  out  CNT_W  saturating count of stall cycles

## Operation
- Storage: shift queue slot[0..DEPTH-1], each {valid, rd, load}. slot[0] = instruction now in EX, slot[j] = j stages further on.
- Every cycle: slot[j] <= slot[j-1] for j≥1. Slot[DEPTH-1] retires.
- slot[0] <= {1, rd_i, is_load_i} when accepted = issue_i & ~kill_i & ~stall_o & rd_wen_i & (rd_i≠0).
- Otherwise slot[0] <= invalid (bubble).
- Source match for rsN: rsN_used & rsN≠0 & slot[j].valid & slot[j].rd==rsN.
- The youngest match (smallest j) wins.
- Distance when consumer reaches EX = j+1.
- distN_o = j+1 on match, else 0. Output is combinational from the queue and ID inputs.
- Load-use hazard: the winning match is a load with j+1 < LOAD_DIST.
- stall_o = issue_i & ~kill_i & (hazard on rs1 | hazard on rs2).
- kill_i dominates: no stall, no slot entry.
- While stalled, distN_o still reports the current match. The consumer re-evaluates next cycle with the producer one slot further on.
- Register file is write-through, so a producer leaving slot[DEPTH-1] is visible as dist 0 the next cycle.
- stall_cnt_o increments on each cycle with stall_o=1 and saturates at all-ones.

## Timing
- Reset (rst_i high at edge): all slots invalid and stall_cnt_o=0. stall_o=0 and dist*_o=0 follow combinationally.
- Rst_i mid-stream discards all in-flight tracking in the same edge.
- Latency: an issue at edge t is visible as dist 1 to the ID instruction in cycle t+1. It becomes dist k in cycle t+k and is gone after DEPTH cycles.
- Load followed immediately by a dependent instruction, with default parameters:
  - exactly 1 stall cycle;
  - after the stall, dist = 2.
- Stall with a simultaneous retire of an unrelated producer: the queue still shifts and a bubble enters slot[0].
- Both sources matching different slots: each distN is independent. The stall is the OR of both.
- The same rd in multiple slots: always report the youngest.
- Counter saturation: at all-ones, a further stall cycle holds the value.

## Test plan
- ALU chain, default parameters:
  - stimulus: issue add x5; next cycle ID reads rs1=x5.
  - response: stall_o=0, dist1_o=1.
  - one cycle later, an independent issue reading x5: dist1_o=2.
- Load-use:
  - stimulus: issue load x7; next cycle ID reads rs2=x7.
  - response: stall_o=1 for 1 cycle, stall_cnt_o=1; following cycle stall_o=0, dist2_o=2.
- x0 and unused operand:
  - stimulus: issue load writing x0; next reads rs1=0. Also rs2=x7 with rs2_used_i=0 after a load x7.
  - response: stall_o=0 and dist=0 in both cases.
- Youngest wins:
  - stimulus: issue x3 (ALU) twice back-to-back, then read x3.
  - response: dist1_o=1, not 2.
  - DEPTH cycles after the last issue: dist1_o=0.
- Kill and reset:
  - kill_i=1 on a load issue: no slot entry; next consumer sees dist 0, no stall.
  - rst_i during a load-use stall: stall_o=0, stall_cnt_o=0 next cycle.
- Parameter sweep with DEPTH=5, LOAD_DIST=3, CNT_W=2:
  - load-use gives 2 stall cycles.
  - the counter saturates at 3 after a further stall.

Source files
------------

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : In-flight writer queue giving load-use stall, forwarding distance
//            and a saturating stall-cycle counter.
// Revision : 1.0
// ============================================================================
module hazard_scoreboard #(
  parameter int ADDR_W    = 5,
  parameter int DEPTH     = 3,
  parameter int LOAD_DIST = 2,
  parameter int DIST_W    = 2,
  parameter int CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_i,
  input  logic              kill_i,
  input  logic [ADDR_W-1:0] rd_i,
  input  logic              rd_wen_i,
  input  logic              is_load_i,
  input  logic [ADDR_W-1:0] rs1_i,
  input  logic [ADDR_W-1:0] rs2_i,
  input  logic              rs1_used_i,
  input  logic              rs2_used_i,
  output logic              stall_o,
  output logic [DIST_W-1:0] dist1_o,
  output logic [DIST_W-1:0] dist2_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic              r_vld [DEPTH];
  logic [ADDR_W-1:0] r_rd  [DEPTH];
  logic              r_ld  [DEPTH];
  logic [CNT_W-1:0]  r_cnt;

  logic              w_haz1, w_haz2, w_stall, w_accept;
  logic [DIST_W-1:0] w_dist1, w_dist2;
  logic              w_src1_ok, w_src2_ok;

  assign w_src1_ok = rs1_used_i && (rs1_i != '0);
  assign w_src2_ok = rs2_used_i && (rs2_i != '0);

  // Scan oldest to youngest so the youngest matching producer overrides.
  always_comb begin
    w_dist1 = '0;
    w_dist2 = '0;
    w_haz1  = 1'b0;
    w_haz2  = 1'b0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (w_src1_ok && r_vld[j] && (r_rd[j] == rs1_i)) begin
        w_dist1 = DIST_W'(j + 1);
        w_haz1  = r_ld[j] && ((j + 1) < LOAD_DIST);
      end
      if (w_src2_ok && r_vld[j] && (r_rd[j] == rs2_i)) begin
        w_dist2 = DIST_W'(j + 1);
        w_haz2  = r_ld[j] && ((j + 1) < LOAD_DIST);
      end
    end
  end

  assign w_stall  = issue_i && !kill_i && (w_haz1 || w_haz2);
  assign w_accept = issue_i && !kill_i && !w_stall && rd_wen_i && (rd_i != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int j = 0; j < DEPTH; j++) begin
        r_vld[j] <= 1'b0;
        r_rd[j]  <= '0;
        r_ld[j]  <= 1'b0;
      end
      r_cnt <= '0;
    end else begin
      for (int j = 1; j < DEPTH; j++) begin
        r_vld[j] <= r_vld[j-1];
        r_rd[j]  <= r_rd[j-1];
        r_ld[j]  <= r_ld[j-1];
      end
      r_vld[0] <= w_accept;
      r_rd[0]  <= w_accept ? rd_i : '0;
      r_ld[0]  <= w_accept && is_load_i;
      if (w_stall && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_o     = w_stall;
  assign dist1_o     = w_dist1;
  assign dist2_o     = w_dist2;
  assign stall_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Directed checks of hazard_scoreboard, default and deep/slow-load.
// Revision : 1.0
// ============================================================================
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic       issue, kill, rd_wen, is_load, rs1_used, rs2_used;
  logic [4:0] rd, rs1, rs2;

  logic        a_stall, b_stall;
  logic [1:0]  a_d1, a_d2;
  logic [2:0]  b_d1, b_d2;
  logic [15:0] a_cnt;
  logic [1:0]  b_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_scoreboard u_dut_a (
    .clk_i(clk), .rst_i(rst_a), .issue_i(issue), .kill_i(kill), .rd_i(rd),
    .rd_wen_i(rd_wen), .is_load_i(is_load), .rs1_i(rs1), .rs2_i(rs2),
    .rs1_used_i(rs1_used), .rs2_used_i(rs2_used), .stall_o(a_stall),
    .dist1_o(a_d1), .dist2_o(a_d2), .stall_cnt_o(a_cnt)
  );

  hazard_scoreboard #(.DEPTH(5), .LOAD_DIST(3), .DIST_W(3), .CNT_W(2)) u_dut_b (
    .clk_i(clk), .rst_i(rst_b), .issue_i(issue), .kill_i(kill), .rd_i(rd),
    .rd_wen_i(rd_wen), .is_load_i(is_load), .rs1_i(rs1), .rs2_i(rs2),
    .rs1_used_i(rs1_used), .rs2_used_i(rs2_used), .stall_o(b_stall),
    .dist1_o(b_d1), .dist2_o(b_d2), .stall_cnt_o(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic id(input logic iss, input logic kil, input logic [4:0] d,
                    input logic wen, input logic ld,
                    input logic [4:0] s1, input logic u1,
                    input logic [4:0] s2, input logic u2);
    issue = iss; kill = kil; rd = d; rd_wen = wen; is_load = ld;
    rs1 = s1; rs1_used = u1; rs2 = s2; rs2_used = u2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) step();
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    rst_a = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_stall", a_stall, 0);
    chk("rst_d1", a_d1, 0);
    chk("rst_d2", a_d2, 0);
    chk("rst_cnt", a_cnt, 0);
    step();

    // ALU chain: add x5, then consumers of x5 at increasing distance
    id(1, 0, 5, 1, 0, 0, 0, 0, 0); step();
    id(1, 0, 6, 1, 0, 5, 1, 0, 0);
    @(negedge clk);
    chk("alu_stall", a_stall, 0);
    chk("alu_d1_1", a_d1, 1);
    step();
    id(1, 0, 0, 0, 0, 5, 1, 0, 0);
    @(negedge clk);
    chk("alu_d1_2", a_d1, 2);
    step();
    @(negedge clk);
    chk("alu_d1_3", a_d1, 3);
    step();
    @(negedge clk);
    chk("alu_retired", a_d1, 0);
    step();
    idle(3);

    // Load-use: exactly one stall, then forward from distance 2
    id(1, 0, 7, 1, 1, 0, 0, 0, 0); step();
    id(1, 0, 8, 1, 0, 0, 0, 7, 1);
    @(negedge clk);
    chk("lu_stall", a_stall, 1);
    chk("lu_d2_1", a_d2, 1);
    step();
    @(negedge clk);
    chk("lu_unstall", a_stall, 0);
    chk("lu_d2_2", a_d2, 2);
    chk("lu_cnt", a_cnt, 1);
    step();
    idle(3);

    // Load to x0, then read x0
    id(1, 0, 0, 1, 1, 0, 0, 0, 0); step();
    id(1, 0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("x0_stall", a_stall, 0);
    chk("x0_d1", a_d1, 0);
    step();
    // Load x7, then rs2=x7 not used
    id(1, 0, 7, 1, 1, 0, 0, 0, 0); step();
    id(1, 0, 0, 0, 0, 0, 0, 7, 0);
    @(negedge clk);
    chk("unused_stall", a_stall, 0);
    chk("unused_d2", a_d2, 0);
    step();
    idle(3);

    // Youngest wins: two writers of x3 back to back
    id(1, 0, 3, 1, 0, 0, 0, 0, 0); step();
    step();
    id(1, 0, 0, 0, 0, 3, 1, 0, 0);
    @(negedge clk);
    chk("young_d1_1", a_d1, 1);
    step();
    id(0, 0, 0, 0, 0, 3, 1, 0, 0);
    @(negedge clk);
    chk("young_d1_2", a_d1, 2);
    step();
    @(negedge clk);
    chk("young_d1_3", a_d1, 3);
    step();
    @(negedge clk);
    chk("young_gone", a_d1, 0);
    step();
    idle(3);

    // Killed load leaves no entry
    id(1, 1, 9, 1, 1, 0, 0, 0, 0); step();
    id(1, 0, 0, 0, 0, 9, 1, 0, 0);
    @(negedge clk);
    chk("kill_stall", a_stall, 0);
    chk("kill_d1", a_d1, 0);
    step();
    // Kill on the dependent suppresses the stall but distance still reports
    id(1, 0, 9, 1, 1, 0, 0, 0, 0); step();
    id(1, 1, 0, 0, 0, 9, 1, 0, 0);
    @(negedge clk);
    chk("killdep_stall", a_stall, 0);
    chk("killdep_d1", a_d1, 1);
    step();
    idle(3);

    // Reset during a load-use stall
    id(1, 0, 7, 1, 1, 0, 0, 0, 0); step();
    id(1, 0, 8, 1, 0, 0, 0, 7, 1);
    @(negedge clk);
    chk("rstmid_stall_pre", a_stall, 1);
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    @(negedge clk);
    chk("rstmid_stall", a_stall, 0);
    chk("rstmid_cnt", a_cnt, 0);
    chk("rstmid_d2", a_d2, 0);
    step();
    idle(2);

    // DEPTH=5, LOAD_DIST=3, CNT_W=2 instance
    rst_b = 1'b0;
    @(negedge clk);
    chk("b_rst_cnt", b_cnt, 0);
    step();
    id(1, 0, 7, 1, 1, 0, 0, 0, 0); step();
    id(1, 0, 8, 1, 0, 0, 0, 7, 1);
    @(negedge clk);
    chk("b_stall_1", b_stall, 1);
    step();
    @(negedge clk);
    chk("b_stall_2", b_stall, 1);
    chk("b_d2_2", b_d2, 2);
    step();
    @(negedge clk);
    chk("b_unstall", b_stall, 0);
    chk("b_d2_3", b_d2, 3);
    chk("b_cnt_2", b_cnt, 2);
    step();
    id(1, 0, 7, 1, 1, 0, 0, 0, 0); step();
    id(1, 0, 0, 0, 0, 7, 1, 0, 0);
    @(negedge clk);
    chk("b_stall_3", b_stall, 1);
    step();
    @(negedge clk);
    chk("b_cnt_3", b_cnt, 3);
    chk("b_stall_4", b_stall, 1);
    step();
    @(negedge clk);
    chk("b_cnt_sat", b_cnt, 3);
    chk("b_unstall_2", b_stall, 0);
    chk("b_d1_3", b_d1, 3);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
